// File: rtl/brushless_commutator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// brushless_commutator : six-step hall commutator with RUN/BRAKE/FAULT control
// Optional macro BRAKE_RAMP_EN : ramp duty toward BRAKE_DUTY in 16-count steps
// Revision : 1.0  initial release
// ============================================================================
module brushless_commutator #(
  parameter int                 DRV_W      = 12,
  parameter int                 DUTY_W     = 11,
  parameter logic [DUTY_W-1:0]  BRAKE_DUTY = 11'h600,
  parameter int                 FLT_CNT    = 2,
  parameter int                 STALL_LIM  = 1024,
  parameter int                 PER_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DRV_W-1:0]  drv_mag,
  input  logic              PWM_synch,
  input  logic              hallGrn,
  input  logic              hallYlw,
  input  logic              hallBlu,
  input  logic              brake_n,
  input  logic              dir,
  input  logic              flt_clr,
  output logic [1:0]        selGrn,
  output logic [1:0]        selYlw,
  output logic [1:0]        selBlu,
  output logic [DUTY_W-1:0] duty,
  output logic              fault,
  output logic              stall,
  output logic [PER_W-1:0]  hall_period
);

  localparam int                STL_W     = $clog2(STALL_LIM + 1);
  localparam int                FC_W      = $clog2(FLT_CNT + 1);
  localparam logic [STL_W-1:0]  STL_MAX   = STL_W'(STALL_LIM);
  localparam logic [FC_W-1:0]   FC_MAX    = FC_W'(FLT_CNT);
  localparam logic [DUTY_W-1:0] MID_DUTY  = {1'b1, {(DUTY_W-1){1'b0}}};

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    BRAKE = 2'd1,
    FAULT = 2'd2
  } state_e;

  function automatic logic [2:0] fwd_next(input logic [2:0] c);
    case (c)
      3'b101:  fwd_next = 3'b100;
      3'b100:  fwd_next = 3'b110;
      3'b110:  fwd_next = 3'b010;
      3'b010:  fwd_next = 3'b011;
      3'b011:  fwd_next = 3'b001;
      3'b001:  fwd_next = 3'b101;
      default: fwd_next = 3'b000;
    endcase
  endfunction

  function automatic logic valid_code(input logic [2:0] c);
    return (c != 3'b000) && (c != 3'b111);
  endfunction

  // Reversing swaps the two bits of each coil pair: 10 <-> 01, 00 stays 00.
  function automatic logic [5:0] drive(input logic [2:0] c, input logic rev);
    logic [5:0] s;
    case (c)
      3'b101:  s = 6'b10_01_00;
      3'b100:  s = 6'b10_00_01;
      3'b110:  s = 6'b00_10_01;
      3'b010:  s = 6'b01_10_00;
      3'b011:  s = 6'b01_00_10;
      3'b001:  s = 6'b00_01_10;
      default: s = 6'b00_00_00;
    endcase
    if (rev) s = {s[4], s[5], s[2], s[3], s[0], s[1]};
    return s;
  endfunction

`ifdef BRAKE_RAMP_EN
  localparam logic [DUTY_W-1:0] RAMP_STEP = DUTY_W'(16);

  function automatic logic [DUTY_W-1:0] ramp(input logic [DUTY_W-1:0] d);
    if (d < BRAKE_DUTY)
      return ((BRAKE_DUTY - d) <= RAMP_STEP) ? BRAKE_DUTY : d + RAMP_STEP;
    else
      return ((d - BRAKE_DUTY) <= RAMP_STEP) ? BRAKE_DUTY : d - RAMP_STEP;
  endfunction
`endif

  logic [2:0]        sync1_q, sync2_q;
  logic [2:0]        cur_code_q, cur_code_d;
  logic [2:0]        prev_code_q, prev_code_d;
  logic [FC_W-1:0]   inv_cnt_q, inv_cnt_d;
  logic [STL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
  logic [PER_W-1:0]  period_q, period_d;
  logic              cap_q;
  logic [5:0]        sel_q, sel_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  state_e            state_q, state_d;

  logic              code_change;
  logic              step_illegal;
  logic              inv_fault;
  logic              hall_chg;
  logic              unused_drv;

  assign unused_drv = ^drv_mag;

  always_comb begin
    cur_code_d   = cur_code_q;
    prev_code_d  = prev_code_q;
    inv_cnt_d    = inv_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    per_cnt_d    = per_cnt_q;
    period_d     = period_q;
    sel_d        = sel_q;
    duty_d       = duty_q;
    state_d      = state_q;

    code_change  = PWM_synch && (sync2_q != cur_code_q);
    // A jump is only judged when both ends are valid codes, which also leaves
    // the first valid capture after reset (cur_code = 000) unchecked.
    step_illegal = code_change && valid_code(sync2_q) && valid_code(cur_code_q) &&
                   (sync2_q != fwd_next(cur_code_q)) &&
                   (cur_code_q != fwd_next(sync2_q));
    inv_fault    = PWM_synch && !valid_code(sync2_q) && (inv_cnt_q >= FC_MAX - 1'b1);
    hall_chg     = cap_q && (cur_code_q != prev_code_q);

    if (PWM_synch) begin
      cur_code_d  = sync2_q;
      prev_code_d = cur_code_q;
      if (valid_code(sync2_q))  inv_cnt_d = '0;
      else if (inv_cnt_q != FC_MAX) inv_cnt_d = inv_cnt_q + 1'b1;
    end

    unique case (state_q)
      RUN:     if (PWM_synch && !brake_n) state_d = BRAKE;
      BRAKE:   if (PWM_synch && brake_n)  state_d = RUN;
      FAULT:   if (flt_clr && valid_code(cur_code_q)) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (step_illegal || inv_fault) state_d = FAULT;

    if (PWM_synch || (state_d != state_q)) begin
      unique case (state_d)
        RUN: begin
          sel_d  = drive(cur_code_d, dir);
          duty_d = {1'b1, drv_mag[DRV_W-1 -: DUTY_W-1]};
        end
        BRAKE: begin
          sel_d  = 6'b11_11_11;
`ifdef BRAKE_RAMP_EN
          duty_d = ramp(duty_q);
`else
          duty_d = BRAKE_DUTY;
`endif
        end
        default: begin
          sel_d  = 6'b00_00_00;
          duty_d = MID_DUTY;
        end
      endcase
    end

    if ((state_d != RUN) || code_change)
      stall_cnt_d = '0;
    else if (PWM_synch && (state_q == RUN) && (stall_cnt_q != STL_MAX))
      stall_cnt_d = stall_cnt_q + 1'b1;

    if (per_cnt_q != {PER_W{1'b1}}) per_cnt_d = per_cnt_q + 1'b1;
    if (hall_chg) begin
      period_d  = per_cnt_q;
      per_cnt_d = PER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cur_code_q  <= '0;
      prev_code_q <= '0;
      inv_cnt_q   <= '0;
      stall_cnt_q <= '0;
      per_cnt_q   <= '0;
      period_q    <= '0;
      cap_q       <= 1'b0;
      sel_q       <= '0;
      duty_q      <= MID_DUTY;
      state_q     <= RUN;
    end else begin
      sync1_q     <= {hallGrn, hallYlw, hallBlu};
      sync2_q     <= sync1_q;
      cur_code_q  <= cur_code_d;
      prev_code_q <= prev_code_d;
      inv_cnt_q   <= inv_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      per_cnt_q   <= per_cnt_d;
      period_q    <= period_d;
      cap_q       <= PWM_synch;
      sel_q       <= sel_d;
      duty_q      <= duty_d;
      state_q     <= state_d;
    end
  end

  assign selGrn      = sel_q[5:4];
  assign selYlw      = sel_q[3:2];
  assign selBlu      = sel_q[1:0];
  assign duty        = duty_q;
  assign fault       = (state_q == FAULT);
  assign stall       = (stall_cnt_q == STL_MAX);
  assign hall_period = period_q;

endmodule
`default_nettype wire

// File: tb/tb_brushless_commutator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_brushless_commutator : directed self-checking bench for the commutator
// Revision : 1.0  initial release
// ============================================================================
module tb_brushless_commutator;

  logic        clk, rst;
  logic [11:0] drv_mag;
  logic        PWM_synch, hallGrn, hallYlw, hallBlu, brake_n, dir, flt_clr;
  logic [1:0]  selGrn, selYlw, selBlu;
  logic [10:0] duty;
  logic        fault, stall;
  logic [13:0] hall_period;

  int total = 0;
  int bad   = 0;

  brushless_commutator #(.PER_W(14)) dut (
    .clk(clk), .rst(rst), .drv_mag(drv_mag), .PWM_synch(PWM_synch),
    .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
    .brake_n(brake_n), .dir(dir), .flt_clr(flt_clr),
    .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
    .duty(duty), .fault(fault), .stall(stall), .hall_period(hall_period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    PWM_synch = 1'b1;
    @(negedge clk);
    PWM_synch = 1'b0;
  endtask

  task automatic step(input logic [2:0] c);
    {hallGrn, hallYlw, hallBlu} = c;
    repeat (3) @(negedge clk);
    pulse();
  endtask

  task automatic period_step(input logic [2:0] c, input int gap);
    {hallGrn, hallYlw, hallBlu} = c;
    repeat (gap - 1) @(negedge clk);
    pulse();
  endtask

  task automatic clear_fault();
    flt_clr = 1'b1;
    @(negedge clk);
    flt_clr = 1'b0;
  endtask

  logic [2:0] seq   [0:6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
  logic [5:0] exp_f [0:6] = '{6'b100100, 6'b100001, 6'b001001, 6'b011000,
                              6'b010010, 6'b000110, 6'b100100};
  logic [5:0] exp_r [0:6] = '{6'b011000, 6'b010010, 6'b000110, 6'b100100,
                              6'b100001, 6'b001001, 6'b011000};

  initial begin
    rst = 1'b1; drv_mag = 12'hFFC; PWM_synch = 1'b0;
    {hallGrn, hallYlw, hallBlu} = 3'b101;
    brake_n = 1'b1; dir = 1'b0; flt_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sel",    {selGrn, selYlw, selBlu}, 6'b0);
    chk("rst_duty",   duty, 11'h400);
    chk("rst_fault",  fault, 1'b0);
    chk("rst_stall",  stall, 1'b0);
    chk("rst_period", hall_period, 14'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      step(seq[i]);
      chk($sformatf("fwd_sel_%0d", i), {selGrn, selYlw, selBlu}, exp_f[i]);
    end
    chk("fwd_duty",  duty, 11'h7FF);
    chk("fwd_fault", fault, 1'b0);

    dir = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(seq[i]);
      chk($sformatf("rev_sel_%0d", i), {selGrn, selYlw, selBlu}, exp_r[i]);
    end
    dir = 1'b0;

    drv_mag = 12'h000;
    pulse();
    chk("run_duty_zero", duty, 11'h400);
    brake_n = 1'b0;
    pulse();
    chk("brake_sel", {selGrn, selYlw, selBlu}, 6'b111111);
`ifdef BRAKE_RAMP_EN
    chk("ramp_1", duty, 11'h410);
    pulse();
    chk("ramp_2", duty, 11'h420);
    repeat (29) pulse();
    chk("ramp_31", duty, 11'h5F0);
    pulse();
    chk("ramp_32", duty, 11'h600);
    pulse();
    chk("ramp_hold", duty, 11'h600);
`else
    chk("brake_duty", duty, 11'h600);
`endif
    brake_n = 1'b1;
    pulse();
    chk("unbrake_sel",  {selGrn, selYlw, selBlu}, 6'b100100);
    chk("unbrake_duty", duty, 11'h400);
    drv_mag = 12'hFFC;

    brake_n = 1'b0;
    pulse();
    chk("brake2_sel", {selGrn, selYlw, selBlu}, 6'b111111);
    #2 rst = 1'b1;
    #1;
    chk("arst_sel",    {selGrn, selYlw, selBlu}, 6'b0);
    chk("arst_duty",   duty, 11'h400);
    chk("arst_fault",  fault, 1'b0);
    chk("arst_period", hall_period, 14'd0);
    @(negedge clk);
    rst = 1'b0;
    brake_n = 1'b1;
    @(negedge clk);

    step(3'b101);
    chk("first_cap_sel", {selGrn, selYlw, selBlu}, 6'b100100);
    chk("first_cap_fault", fault, 1'b0);
    step(3'b110);
    chk("illegal_fault", fault, 1'b1);
    chk("illegal_sel",   {selGrn, selYlw, selBlu}, 6'b0);
    chk("illegal_duty",  duty, 11'h400);
    clear_fault();
    chk("clr_fault", fault, 1'b0);
    chk("clr_sel",   {selGrn, selYlw, selBlu}, 6'b001001);
    chk("clr_duty",  duty, 11'h7FF);

    step(3'b000);
    chk("one_inv_fault", fault, 1'b0);
    chk("one_inv_sel",   {selGrn, selYlw, selBlu}, 6'b0);
    step(3'b110);
    chk("inv_back_fault", fault, 1'b0);
    step(3'b000);
    chk("inv_a_fault", fault, 1'b0);
    step(3'b000);
    chk("inv_b_fault", fault, 1'b1);
    step(3'b110);
    clear_fault();
    chk("clr2_fault", fault, 1'b0);

    step(3'b010);
    chk("stall_start", stall, 1'b0);
    repeat (1023) pulse();
    chk("stall_1023", stall, 1'b0);
    pulse();
    chk("stall_1024", stall, 1'b1);
    chk("stall_nofault", fault, 1'b0);
    step(3'b011);
    chk("stall_clear", stall, 1'b0);

    period_step(3'b001, 5000);
    period_step(3'b101, 5000);
    @(negedge clk);
    chk("period_5000", hall_period, 14'd5000);
    period_step(3'b100, 17000);
    @(negedge clk);
    chk("period_sat", hall_period, 14'h3FFF);
    chk("final_fault", fault, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/brushless_commutator.md
BRUSHLESS_COMMUTATOR -- requirements
Module: brushless_commutator

Interface
REQ-001 Parameter DRV_W, 12, drive magnitude width; SHALL satisfy DRV_W >= DUTY_W-1.
REQ-002 Parameter DUTY_W, 11, duty output width.
REQ-003 Parameter BRAKE_DUTY, 11'h600, braking duty (75%).
REQ-004 Parameter FLT_CNT, 2, consecutive invalid hall samples that trigger a fault.
REQ-005 Parameter STALL_LIM, 1024, PWM_synch events without a hall change before stall is flagged.
REQ-006 Parameter PER_W, 20, hall period counter width.
REQ-007 Ports: clk input 1, system clock; one clock domain; reset is asynchronous and active-high (rst input 1).
REQ-008 Port drv_mag input DRV_W, drive magnitude.
REQ-009 Port PWM_synch input 1, one-cycle pulse; commutation updates only on it.
REQ-010 Ports hallGrn/hallYlw/hallBlu input 1 each, asynchronous hall sensors.
REQ-011 Ports brake_n input 1, active-low brake request; dir input 1, 0 = forward, 1 = reverse; flt_clr input 1, fault clear pulse.
REQ-012 Ports selGrn/selYlw/selBlu output 2 each, coil select: 00 HIGH_Z, 01 LOW_PWM, 10 HIGH_PWM, 11 BRAKE.
REQ-013 Port duty output DUTY_W, FET duty; fault output 1; stall output 1; hall_period output PER_W, clk cycles between the last two hall changes.

Function
REQ-014 Each hall input SHALL pass through two synchronizer flops before use.
REQ-015 On PWM_synch, the synchronized hall code {Grn,Ylw,Blu} SHALL be captured into cur_code, and the old value into prev_code.
REQ-016 The forward sequence is 101->100->110->010->011->001->101. A captured code that differs from prev_code and is not one step away in either direction is illegal.
REQ-017 Codes 000/111 are invalid. A run of FLT_CNT consecutive invalid captures SHALL assert fault, and so SHALL any illegal step.
REQ-018 FSM states RUN, BRAKE, FAULT. RUN->BRAKE when brake_n=0 at PWM_synch; BRAKE->RUN when brake_n=1 at PWM_synch; any state->FAULT on a fault condition; FAULT->RUN on flt_clr=1 with a valid cur_code. FAULT has priority over brake.
REQ-019 RUN drive table (forward, Grn/Ylw/Blu): 101 = 10/01/00, 100 = 10/00/01, 110 = 00/10/01, 010 = 01/10/00, 011 = 01/00/10, 001 = 00/01/10. An invalid code in RUN gives all 00.
REQ-020 When dir=1, 10 and 01 SHALL be swapped on the driven coils; 00 is unchanged.
REQ-021 In BRAKE all sel = 11. In FAULT all sel = 00.
REQ-022 RUN duty = 2^(DUTY_W-1) + drv_mag[DRV_W-1 -: DUTY_W-1] (default 0x400 + drv_mag[11:2]); this SHALL never overflow. BRAKE duty = BRAKE_DUTY. FAULT duty = 2^(DUTY_W-1).
REQ-023 sel and duty SHALL be registered and SHALL change exactly one clk after the PWM_synch cycle that changed the code or state.
REQ-024 Stall counter: increments on each PWM_synch in RUN with cur_code unchanged. It clears on a code change or when leaving RUN, and saturates at STALL_LIM. stall = (count == STALL_LIM); stall SHALL NOT cause a fault.
REQ-025 Period counter: increments every clk and saturates at all-ones. On each captured code change, hall_period SHALL load the counter value and the counter SHALL restart at 1.

Reset
REQ-026 rst SHALL asynchronously clear all synchronizers, cur_code, prev_code and counters. After reset: state RUN, all sel 00, duty 2^(DUTY_W-1), fault 0, stall 0, hall_period 0.
REQ-027 The first valid capture after reset SHALL NOT be checked for legality.
REQ-028 Reset asserted mid-operation SHALL override brake, fault and ramp immediately.

Configuration
REQ-029 With macro BRAKE_RAMP_EN defined, on entry to BRAKE the duty SHALL step from its current value toward BRAKE_DUTY by 16 per PWM_synch, without overshoot, and then hold. Any exit from BRAKE aborts the ramp.
REQ-030 Without BRAKE_RAMP_EN, duty SHALL switch to BRAKE_DUTY in the same cycle as sel.

Verification
REQ-031 Forward rotation through 101,100,110,010,011,001 with drv_mag=0xFFC -> sel follows the REQ-019 table one clk after each PWM_synch; duty=0x7FF.
REQ-032 Same sequence with dir=1 -> each step shows 01/10 swapped, e.g. 101 gives 01/10/00.
REQ-033 brake_n=0 at PWM_synch -> sel=11/11/11 and duty=0x600. With BRAKE_RAMP_EN and a starting duty of 0x400 -> 0x410, 0x420, ... reaching 0x600 after 32 PWM_synch.
REQ-034 Illegal jump 101->110 -> fault=1 and sel=00; flt_clr with code 110 -> RUN, sel=00/10/01. Two captures of 000 -> fault; a single 000 -> no fault.
REQ-035 Hall held constant for 1024 PWM_synch -> stall=1 and fault=0. Hall changes every 5000 clk -> hall_period=5000. Hall held for more than 2^20 clk -> hall_period=0xFFFFF.
REQ-036 rst asserted mid-brake -> all outputs take their reset values asynchronously.
